// File: rtl/cdb_broadcast_pkg.sv
// Shared CDB definitions: field widths, default sizing and the broadcast packet
// that the RS/ROB snoop ports reuse.
package cdb_broadcast_pkg;

  localparam int FU_PORTS  = 4;
  localparam int CDB_LANES = 2;
  localparam int TAG_W     = 5;
  localparam int DATA_W    = 64;
  localparam int ROB_SIZE  = 32;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [DATA_W-1:0]    value;
    logic [ROB_IDX_W-1:0] rob_index;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_broadcast_arbiter.sv
// Round-robin multi-grant arbiter: scans requests from ptr_i upward (mod NUM_FU)
// and hands the first CDB_WIDTH requesters to lanes 0, 1, ... in scan order.
module rr_multi_arbiter #(
  parameter int NUM_FU    = 4,
  parameter int CDB_WIDTH = 2,
  localparam int PTR_W    = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]                 req_i,
  input  logic [PTR_W-1:0]                  ptr_i,
  output logic [CDB_WIDTH-1:0][NUM_FU-1:0]  lane_grant_o,
  output logic [CDB_WIDTH-1:0]              lane_valid_o,
  output logic [NUM_FU-1:0]                 grant_o,
  output logic [PTR_W-1:0]                  ptr_next_o
);

  always_comb begin
    int cnt;
    cnt          = 0;
    lane_grant_o = '0;
    lane_valid_o = '0;
    grant_o      = '0;
    ptr_next_o   = ptr_i;
    // Outer loop walks scan order; inner loop maps the scan position to a slot.
    for (int o = 0; o < NUM_FU; o++) begin
      for (int j = 0; j < NUM_FU; j++) begin
        if (((int'(ptr_i) + o) % NUM_FU == j) && req_i[j] && (cnt < CDB_WIDTH)) begin
          grant_o[j] = 1'b1;
          for (int k = 0; k < CDB_WIDTH; k++) begin
            if (k == cnt) begin
              lane_grant_o[k][j] = 1'b1;
              lane_valid_o[k]    = 1'b1;
            end
          end
          cnt        = cnt + 1;
          ptr_next_o = PTR_W'((j + 1) % NUM_FU);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast.sv
// CDB transmit end: one holding slot per FU, round-robin lane assignment and
// registered broadcast lanes with zeroed idle fields.
module cdb_broadcast
  import cdb_broadcast_pkg::*;
#(
  parameter int NUM_FU    = FU_PORTS,
  parameter int CDB_WIDTH = CDB_LANES
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    fu_valid_in,
  input  logic [NUM_FU-1:0][TAG_W-1:0]         fu_tag_in,
  input  logic [NUM_FU-1:0][DATA_W-1:0]        fu_value_in,
  input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_rob_index_in,
  output logic [NUM_FU-1:0]                    fu_ready_out,
  output logic [CDB_WIDTH-1:0]                 cdb_valid_out,
  output logic [CDB_WIDTH-1:0][TAG_W-1:0]      cdb_tag_out,
  output logic [CDB_WIDTH-1:0][DATA_W-1:0]     cdb_value_out,
  output logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]  cdb_rob_index_out
);

  localparam int PTR_W = $clog2(NUM_FU);

  cdb_pkt_t [NUM_FU-1:0]    slot_q, slot_d;
  cdb_pkt_t [CDB_WIDTH-1:0] lane_q, lane_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d, ptr_next;

  logic [NUM_FU-1:0]                req, grant;
  logic [CDB_WIDTH-1:0][NUM_FU-1:0] lane_grant;
  logic [CDB_WIDTH-1:0]             lane_valid;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_FU; i++) req[i] = slot_q[i].valid;
  end

  rr_multi_arbiter #(
    .NUM_FU    (NUM_FU),
    .CDB_WIDTH (CDB_WIDTH)
  ) u_arb (
    .req_i        (req),
    .ptr_i        (rr_ptr_q),
    .lane_grant_o (lane_grant),
    .lane_valid_o (lane_valid),
    .grant_o      (grant),
    .ptr_next_o   (ptr_next)
  );

  // A granted slot drains this edge, so it can take a new result at the same time.
  assign fu_ready_out = ~{NUM_FU{flush}} & (~req | grant);

  always_comb begin
    slot_d   = slot_q;
    lane_d   = '0;
    rr_ptr_d = ptr_next;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) slot_d[i].valid = 1'b0;
      if (fu_valid_in[i] && fu_ready_out[i]) begin
        slot_d[i].valid     = 1'b1;
        slot_d[i].tag       = fu_tag_in[i];
        slot_d[i].value     = fu_value_in[i];
        slot_d[i].rob_index = fu_rob_index_in[i];
      end
    end
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (lane_valid[k]) begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (lane_grant[k][i]) lane_d[k] = slot_q[i];
        end
      end
    end
    if (flush) begin
      slot_d   = '0;
      lane_d   = '0;
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q   <= '0;
      lane_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      slot_q   <= slot_d;
      lane_q   <= lane_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    cdb_valid_out     = '0;
    cdb_tag_out       = '0;
    cdb_value_out     = '0;
    cdb_rob_index_out = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      cdb_valid_out[k]     = lane_q[k].valid;
      cdb_tag_out[k]       = lane_q[k].tag;
      cdb_value_out[k]     = lane_q[k].value;
      cdb_rob_index_out[k] = lane_q[k].rob_index;
    end
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Self-checking bench for cdb_broadcast against a slot/queue-level reference model.
module tb_cdb_broadcast;

  logic             clock = 1'b0;
  logic             reset, flush;
  logic [3:0]       fu_valid_in;
  logic [3:0][4:0]  fu_tag_in;
  logic [3:0][63:0] fu_value_in;
  logic [3:0][4:0]  fu_rob_index_in;
  logic [3:0]       fu_ready_out;
  logic [1:0]       cdb_valid_out;
  logic [1:0][4:0]  cdb_tag_out;
  logic [1:0][63:0] cdb_value_out;
  logic [1:0][4:0]  cdb_rob_index_out;

  cdb_broadcast dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .fu_valid_in       (fu_valid_in),
    .fu_tag_in         (fu_tag_in),
    .fu_value_in       (fu_value_in),
    .fu_rob_index_in   (fu_rob_index_in),
    .fu_ready_out      (fu_ready_out),
    .cdb_valid_out     (cdb_valid_out),
    .cdb_tag_out       (cdb_tag_out),
    .cdb_value_out     (cdb_value_out),
    .cdb_rob_index_out (cdb_rob_index_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: held results per FU plus a scan start position.
  logic        m_held [4];
  logic [4:0]  m_tag  [4];
  logic [63:0] m_val  [4];
  logic [4:0]  m_rob  [4];
  int          m_ptr;
  logic [1:0]       exp_v;
  logic [1:0][4:0]  exp_tag;
  logic [1:0][63:0] exp_val;
  logic [1:0][4:0]  exp_rob;

  function automatic void model_arb(output int g0, output int g1);
    g0 = -1; g1 = -1;
    for (int o = 0; o < 4; o++) begin
      int i;
      i = (m_ptr + o) % 4;
      if (m_held[i]) begin
        if (g0 < 0) g0 = i;
        else if (g1 < 0) g1 = i;
      end
    end
  endfunction

  function automatic logic [3:0] model_ready();
    int g0, g1;
    logic [3:0] r;
    model_arb(g0, g1);
    for (int i = 0; i < 4; i++) r[i] = !flush && (!m_held[i] || i == g0 || i == g1);
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
    m_ptr = 0; exp_v = '0; exp_tag = '0; exp_val = '0; exp_rob = '0;
  endfunction

  function automatic void model_step();
    int g0, g1, last;
    int g[2];
    logic [3:0] rdy;
    if (reset || flush) begin
      model_clear();
      return;
    end
    model_arb(g0, g1);
    rdy = model_ready();
    g[0] = g0; g[1] = g1;
    for (int k = 0; k < 2; k++) begin
      if (g[k] >= 0) begin
        exp_v[k] = 1'b1; exp_tag[k] = m_tag[g[k]]; exp_val[k] = m_val[g[k]]; exp_rob[k] = m_rob[g[k]];
        m_held[g[k]] = 1'b0;
      end else begin
        exp_v[k] = 1'b0; exp_tag[k] = '0; exp_val[k] = '0; exp_rob[k] = '0;
      end
    end
    last = (g1 >= 0) ? g1 : g0;
    if (last >= 0) m_ptr = (last + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (fu_valid_in[i] && rdy[i]) begin
        m_held[i] = 1'b1; m_tag[i] = fu_tag_in[i]; m_val[i] = fu_value_in[i]; m_rob[i] = fu_rob_index_in[i];
      end
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    fu_valid_in = '0; fu_tag_in = '0; fu_value_in = '0; fu_rob_index_in = '0; flush = 1'b0;
  endtask

  task automatic drive_fu(input int i, input logic [4:0] tag, input logic [63:0] val, input logic [4:0] rob);
    fu_valid_in[i] = 1'b1; fu_tag_in[i] = tag; fu_value_in[i] = val; fu_rob_index_in[i] = rob;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (cdb_valid_out !== 2'b00 || cdb_tag_out !== '0 || cdb_value_out !== '0 || cdb_rob_index_out !== '0) begin
      n_errs++;
      $display("FAIL reset_outputs: got v=%b tag=%h val=%h rob=%h, want all zero", cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_rob_index_out);
    end
    n_checks++;
    if (fu_ready_out !== 4'b1111) begin
      n_errs++;
      $display("FAIL reset_ready: got %b want 1111", fu_ready_out);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      set_idle();
      if (n == 0) drive_fu(2, 5'd7, 64'h55, 5'd3);
      if (n == 2) begin
        drive_fu(0, 5'd10, 64'hA0, 5'd20);
        drive_fu(3, 5'd13, 64'hA3, 5'd23);
      end
      #1;
      n_checks++;
      if (fu_ready_out !== model_ready()) begin
        n_errs++;
        $display("FAIL single_ready n=%0d: got %b want %b", n, fu_ready_out, model_ready());
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k]} !== {exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]}) begin
          n_errs++;
          $display("FAIL single_lane%0d n=%0d: got v=%b tag=%0d val=%h rob=%0d want v=%b tag=%0d val=%h rob=%0d",
                   k, n, cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k], exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]);
        end
      end
      if (n == 1) begin
        n_checks++;
        if (cdb_valid_out !== 2'b01 || cdb_tag_out[0] !== 5'd7 || cdb_value_out[0] !== 64'h55 || cdb_rob_index_out[0] !== 5'd3) begin
          n_errs++;
          $display("FAIL single_c2: got v=%b tag=%0d val=%h rob=%0d want v=01 tag=7 val=55 rob=3", cdb_valid_out, cdb_tag_out[0], cdb_value_out[0], cdb_rob_index_out[0]);
        end
      end
      if (n == 3) begin
        n_checks++;
        if (cdb_tag_out[0] !== 5'd13 || cdb_tag_out[1] !== 5'd10) begin
          n_errs++;
          $display("FAIL single_rrptr: got tags %0d,%0d want 13,10", cdb_tag_out[0], cdb_tag_out[1]);
        end
      end
    end
  endtask

  task automatic test_oversub();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      set_idle();
      if (n == 0) for (int i = 0; i < 4; i++) drive_fu(i, 5'(i + 1), {$urandom, $urandom}, 5'($urandom));
      #1;
      n_checks++;
      if (fu_ready_out !== model_ready()) begin
        n_errs++;
        $display("FAIL oversub_ready n=%0d: got %b want %b", n, fu_ready_out, model_ready());
      end
      if (n == 1 || n == 2) begin
        n_checks++;
        if (fu_ready_out !== ((n == 1) ? 4'b0011 : 4'b1111)) begin
          n_errs++;
          $display("FAIL oversub_ready_fixed n=%0d: got %b", n, fu_ready_out);
        end
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k]} !== {exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]}) begin
          n_errs++;
          $display("FAIL oversub_lane%0d n=%0d: got v=%b tag=%0d val=%h rob=%0d want v=%b tag=%0d val=%h rob=%0d",
                   k, n, cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k], exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]);
        end
      end
      if (n == 1 || n == 2) begin
        n_checks++;
        if (cdb_valid_out !== 2'b11 || cdb_tag_out[0] !== 5'(2 * n - 1) || cdb_tag_out[1] !== 5'(2 * n)) begin
          n_errs++;
          $display("FAIL oversub_order n=%0d: got v=%b tags %0d,%0d want 11 tags %0d,%0d", n, cdb_valid_out, cdb_tag_out[0], cdb_tag_out[1], 2 * n - 1, 2 * n);
        end
      end
    end
  endtask

  task automatic test_sustained();
    int cnt[4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    do_reset();
    for (int n = 0; n < 25; n++) begin
      set_idle();
      if (n < 22) for (int i = 0; i < 4; i++) drive_fu(i, 5'(i + 4 * (n % 8)), {$urandom, $urandom}, 5'($urandom));
      #1;
      n_checks++;
      if (fu_ready_out !== model_ready()) begin
        n_errs++;
        $display("FAIL sustained_ready n=%0d: got %b want %b", n, fu_ready_out, model_ready());
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k]} !== {exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]}) begin
          n_errs++;
          $display("FAIL sustained_lane%0d n=%0d: got v=%b tag=%0d val=%h rob=%0d want v=%b tag=%0d val=%h rob=%0d",
                   k, n, cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k], exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]);
        end
        if (n >= 1 && n <= 20 && cdb_valid_out[k]) cnt[cdb_tag_out[k][1:0]]++;
      end
      if (n >= 1 && n <= 20) begin
        n_checks++;
        if (cdb_valid_out[0] !== 1'b1) begin
          n_errs++;
          $display("FAIL sustained_lane0_busy n=%0d: got %b want 1", n, cdb_valid_out[0]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cnt[i] != 10) begin
        n_errs++;
        $display("FAIL sustained_fair fu%0d: got %0d broadcasts want 10", i, cnt[i]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int n = 0; n < 7; n++) begin
      set_idle();
      if (n == 0) for (int i = 0; i < 3; i++) drive_fu(i, 5'(20 + i), {$urandom, $urandom}, 5'($urandom));
      if (n == 1) begin
        flush = 1'b1;
        drive_fu(1, 5'd30, 64'hDEAD, 5'd1);
      end
      if (n == 3) drive_fu(0, 5'd9, 64'h1234, 5'd17);
      #1;
      n_checks++;
      if (fu_ready_out !== model_ready()) begin
        n_errs++;
        $display("FAIL flush_ready n=%0d: got %b want %b", n, fu_ready_out, model_ready());
      end
      if (n == 1) begin
        n_checks++;
        if (fu_ready_out !== 4'b0000) begin
          n_errs++;
          $display("FAIL flush_ready_zero: got %b want 0000", fu_ready_out);
        end
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k]} !== {exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]}) begin
          n_errs++;
          $display("FAIL flush_lane%0d n=%0d: got v=%b tag=%0d val=%h rob=%0d want v=%b tag=%0d val=%h rob=%0d",
                   k, n, cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k], exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]);
        end
      end
      if (n == 1 || n == 2 || n == 3) begin
        n_checks++;
        if (cdb_valid_out !== 2'b00 || cdb_tag_out !== '0 || cdb_value_out !== '0 || cdb_rob_index_out !== '0) begin
          n_errs++;
          $display("FAIL flush_idle n=%0d: got v=%b tag=%h", n, cdb_valid_out, cdb_tag_out);
        end
      end
      if (n == 4) begin
        n_checks++;
        if (cdb_valid_out !== 2'b01 || cdb_tag_out[0] !== 5'd9 || cdb_value_out[0] !== 64'h1234 || cdb_rob_index_out[0] !== 5'd17) begin
          n_errs++;
          $display("FAIL flush_recover: got v=%b tag=%0d val=%h rob=%0d want v=01 tag=9 val=1234 rob=17", cdb_valid_out, cdb_tag_out[0], cdb_value_out[0], cdb_rob_index_out[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 7; n++) begin
      set_idle();
      if (n == 0) for (int i = 0; i < 4; i++) drive_fu(i, 5'(24 + i), {$urandom, $urandom}, 5'($urandom));
      if (n == 2) begin
        reset = 1'b1;
        drive_fu(3, 5'd31, 64'hBEEF, 5'd9);
      end
      #1;
      cyc();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k]} !== {exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]}) begin
          n_errs++;
          $display("FAIL rstmid_lane%0d n=%0d: got v=%b tag=%0d val=%h rob=%0d want v=%b tag=%0d val=%h rob=%0d",
                   k, n, cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k], exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]);
        end
      end
      if (n == 1) begin
        n_checks++;
        if (cdb_valid_out !== 2'b11) begin
          n_errs++;
          $display("FAIL rstmid_busy: got v=%b want 11", cdb_valid_out);
        end
      end
      if (n >= 2) begin
        n_checks++;
        if (cdb_valid_out !== 2'b00 || cdb_tag_out !== '0 || cdb_value_out !== '0 || cdb_rob_index_out !== '0) begin
          n_errs++;
          $display("FAIL rstmid_dropped n=%0d: got v=%b tag=%h", n, cdb_valid_out, cdb_tag_out);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_idle();
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 4);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 99) < 60) drive_fu(i, 5'($urandom), {$urandom, $urandom}, 5'($urandom));
      #1;
      n_checks++;
      if (fu_ready_out !== model_ready()) begin
        n_errs++;
        $display("FAIL random_ready n=%0d: got %b want %b", n, fu_ready_out, model_ready());
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k]} !== {exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]}) begin
          n_errs++;
          $display("FAIL random_lane%0d n=%0d: got v=%b tag=%0d val=%h rob=%0d want v=%b tag=%0d val=%h rob=%0d",
                   k, n, cdb_valid_out[k], cdb_tag_out[k], cdb_value_out[k], cdb_rob_index_out[k], exp_v[k], exp_tag[k], exp_val[k], exp_rob[k]);
        end
      end
      n_checks++;
      if (cdb_valid_out === 2'b10) begin
        n_errs++;
        $display("FAIL random_packing n=%0d: got v=%b, lane1 valid without lane0", n, cdb_valid_out);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    model_clear();
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = '0; m_val[i] = '0; m_rob[i] = '0;
    end
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_oversub();
    test_sustained();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast.md
Name: cdb_broadcast

Overview:
- Transmit end of the common data bus (CDB): collects completed results from the functional units (FUs) and drives up to CDB_WIDTH (tag, value, ROB index) broadcasts per cycle.
- Reservation stations snoop these broadcasts to wake operands; the ROB uses them to mark entries complete.
- Each FU has a one-entry holding slot. A round-robin multi-grant arbiter shares the lanes fairly; FUs are backpressured with a ready handshake.

Parameters:
- NUM_FU, 4, number of FU result ports; must be >= CDB_WIDTH.
- CDB_WIDTH, 2, broadcast lanes per cycle (2-way superscalar).
- TAG_W, 5, destination tag width.
- DATA_W, 64, result value width.
- ROB_SIZE, 32, ROB entries; ROB index width is $clog2(ROB_SIZE).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash: discard all held and outgoing results
- fu_valid_in  in  NUM_FU  FU i presents a result
- fu_tag_in  in  NUM_FU x TAG_W  destination tag
- fu_value_in  in  NUM_FU x DATA_W  result value
- fu_rob_index_in  in  NUM_FU x $clog2(ROB_SIZE)  ROB index of the instruction
- fu_ready_out  out  NUM_FU  slot i can accept this cycle
- cdb_valid_out  out  CDB_WIDTH  lane carries a broadcast
- cdb_tag_out  out  CDB_WIDTH x TAG_W  broadcast tag
- cdb_value_out  out  CDB_WIDTH x DATA_W  broadcast value
- cdb_rob_index_out  out  CDB_WIDTH x $clog2(ROB_SIZE)  broadcast ROB index

Behaviour:
- Single clock `clock`; reset is synchronous and active-high on `reset`. Reset has priority over flush.
- State per FU slot: slot_valid, tag, value, rob_index. Also rr_ptr [$clog2(NUM_FU)-1:0].
- Reset values:
  - All slots invalid, rr_ptr=0.
  - cdb_valid_out=0 and cdb_tag/value/rob_index_out=0.
  - fu_ready_out=all 1s in the cycle after reset, because it is combinational from empty slots.
- Arbitration (combinational):
  - Scan slots rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first CDB_WIDTH valid slots are granted: first grant -> lane 0, second -> lane 1, and so on.
- Lane packing: lanes fill from 0 upward. Lane k is never valid while lane k-1 is invalid.
- Ready: fu_ready_out[i] = ~flush & (~slot_valid[i] | grant[i]), combinational.
- Accept: when fu_valid_in[i] & fu_ready_out[i], slot i loads the inputs at the next edge.
  - A granted slot may reload in the same edge; the new result replaces the old one, which is broadcast that edge.
- Outputs are registered. At each edge:
  - Granted slot contents go to their lanes with cdb_valid_out=1.
  - Granted slots clear unless they reload in the same edge.
  - Ungranted lanes: valid=0 and tag/value/rob_index=0. RS-side logic relies on zeroed idle lanes.
- Latency: a result accepted in cycle c is in its slot in cycle c+1. If granted in c+1, it is visible on the CDB in cycle c+2. Each lane broadcast lasts exactly one cycle.
- rr_ptr update:
  - If any grant, rr_ptr <= (highest-order granted index in scan order + 1) mod NUM_FU.
  - If no grant, unchanged.
  - Wraps from NUM_FU-1 to 0.
- Fairness: any held slot is granted within ceil(NUM_FU/CDB_WIDTH) cycles.
- Flush: at the next edge, all slots clear, cdb_valid_out=0 with fields zeroed, and rr_ptr=0. fu_ready_out=0 during the flush cycle, so no accepts occur.
- No tag uniqueness check: two lanes may carry the same tag. Correctness of that is upstream's responsibility.
- All slots empty: no lane valid, rr_ptr held.
- Reset mid-operation: held results are dropped. No partial broadcast occurs after the reset edge.

Decomposition:
- Shared package: TAG_W, DATA_W, ROB_SIZE, CDB_WIDTH constants. Packed struct cdb_pkt_t {valid, tag, value, rob_index}, reused by RS/ROB snoop ports.
- One sub-module: rr_multi_arbiter (NUM_FU, CDB_WIDTH). Purely combinational: req vector + rr_ptr -> per-lane one-hot grant + lane valid + next pointer.
- Slots, output registers and pointer stay in cdb_broadcast.

Test Plan:
- Reset: assert reset 2 cycles -> all cdb_valid_out=0, all fields 0, fu_ready_out=4'b1111 afterwards.
- Single result: FU2 valid tag=7, value=0x55, rob=3 in cycle c -> cycle c+2 lane0 valid (7, 0x55, 3), lane1 invalid; rr_ptr=3; FU2 ready stays 1.
- Oversubscription: all 4 FUs valid in cycle c, rr_ptr=0, tags 1..4 ->
  - c+2: lanes carry FU0, FU1.
  - c+3: lanes carry FU2, FU3.
  - fu_ready_out[3:2]=0 in c+1, then 1 in c+2.
- Sustained contention: all FUs valid every cycle for 20 cycles -> each FU broadcast exactly once per 2 cycles. Lane0 valid every cycle after c+2; no starvation.
- Flush: 3 slots held and flush=1 with FU1 valid -> next cycle cdb_valid_out=0, slots empty, FU1 not accepted. A new FU0 result 1 cycle later broadcasts normally 2 cycles after acceptance.
- Reset mid-stream: reset asserted while lanes are valid -> following cycle all outputs 0; a prior held result never appears afterwards.
